// File: rtl/recarga_cartao_if.sv
// Coin/button inputs and card-load outputs of the card top-up controller.
// Macro: none.
// master : drives moeda, sel, confirma, cancela; observes carrega1/2, credito, devolve, rejeita, estado
// slave  : the controller side of the same signals
interface recarga_cartao_if;
    localparam int unsigned CARGA_W  = 2;
    localparam int unsigned CRED_W   = 3;
    localparam int unsigned ESTADO_W = 2;

    logic                moeda;
    logic                sel;
    logic                confirma;
    logic                cancela;
    logic [CARGA_W-1:0]  carrega1;
    logic [CARGA_W-1:0]  carrega2;
    logic [CRED_W-1:0]   credito;
    logic                devolve;
    logic                rejeita;
    logic [ESTADO_W-1:0] estado;

    modport master (
        output moeda, sel, confirma, cancela,
        input  carrega1, carrega2, credito, devolve, rejeita, estado
    );

    modport slave (
        input  moeda, sel, confirma, cancela,
        output carrega1, carrega2, credito, devolve, rejeita, estado
    );
endinterface

// File: rtl/recarga_cartao.sv
// Card top-up controller: accumulates up to 3 coins, then loads them onto the
// selected passenger card on confirm, or refunds them one pulse per coin on
// cancel. Optional inactivity refund is built when RECARGA_TIMEOUT_EN is defined.
// Ports:
//   clk_2    system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      recarga_cartao_if.slave (moeda, sel, confirma, cancela in;
//            carrega1, carrega2, credito, devolve, rejeita, estado out)
// Parameter:
//   TIMEOUT  idle cycles in ACUMULANDO before automatic refund (1-255),
//            only used with RECARGA_TIMEOUT_EN
module recarga_cartao #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic              clk_2,
    input  logic              reset_n,
    recarga_cartao_if.slave   bus
);

    localparam int unsigned CARGA_W = 2;
    localparam int unsigned CRED_W  = 3;
    localparam int unsigned TMR_W   = 8;
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(3);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        ACUMULANDO = 2'd1,
        ENTREGA    = 2'd2,
        DEVOLUCAO  = 2'd3
    } estado_t;

    // Elaboration-time range check on the timeout parameter.
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("recarga_cartao: TIMEOUT must be in 1..255");
    end

    estado_t              estado_q;
    logic [CRED_W-1:0]    credito_q;
    logic [CARGA_W-1:0]   carrega1_q;
    logic [CARGA_W-1:0]   carrega2_q;
    logic                 devolve_q;
    logic                 rejeita_q;
    logic                 alvo_q;
    logic                 moeda_q;
    logic                 confirma_q;
    logic                 cancela_q;
`ifdef RECARGA_TIMEOUT_EN
    logic [TMR_W-1:0]     timer_q;
`endif

    // Rising-edge detection against the previous registered sample.
    logic moeda_ed;
    logic confirma_ed;
    logic cancela_ed;

    assign moeda_ed    = bus.moeda    & ~moeda_q;
    assign confirma_ed = bus.confirma & ~confirma_q;
    assign cancela_ed  = bus.cancela  & ~cancela_q;

    // Controller state, credit and registered output pulses.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            credito_q  <= '0;
            carrega1_q <= '0;
            carrega2_q <= '0;
            devolve_q  <= 1'b0;
            rejeita_q  <= 1'b0;
            alvo_q     <= 1'b0;
            moeda_q    <= 1'b0;
            confirma_q <= 1'b0;
            cancela_q  <= 1'b0;
`ifdef RECARGA_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            moeda_q    <= bus.moeda;
            confirma_q <= bus.confirma;
            cancela_q  <= bus.cancela;
            carrega1_q <= '0;
            carrega2_q <= '0;
            devolve_q  <= 1'b0;
            rejeita_q  <= 1'b0;
`ifdef RECARGA_TIMEOUT_EN
            timer_q    <= '0;
`endif
            case (estado_q)
                OCIOSO: begin
                    credito_q <= '0;
                    if (moeda_ed) begin
                        credito_q <= CRED_W'(1);
                        alvo_q    <= bus.sel;
                        estado_q  <= ACUMULANDO;
                    end
                end
                ACUMULANDO: begin
                    if (cancela_ed) begin
                        // First refund pulse is issued in the first DEVOLUCAO cycle.
                        estado_q  <= DEVOLUCAO;
                        devolve_q <= 1'b1;
                        rejeita_q <= moeda_ed;
                    end else if (confirma_ed) begin
                        // Load value is registered here so it is visible exactly during ENTREGA.
                        estado_q   <= ENTREGA;
                        carrega1_q <= alvo_q ? '0 : CARGA_W'(credito_q);
                        carrega2_q <= alvo_q ? CARGA_W'(credito_q) : '0;
                        rejeita_q  <= moeda_ed;
                    end else if (moeda_ed && (credito_q < CRED_MAX)) begin
                        credito_q <= credito_q + CRED_W'(1);
                    end else begin
                        // Idle cycle, or a coin refused at the credit limit.
                        rejeita_q <= moeda_ed;
`ifdef RECARGA_TIMEOUT_EN
                        if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                            estado_q  <= DEVOLUCAO;
                            devolve_q <= 1'b1;
                        end else begin
                            timer_q <= timer_q + TMR_W'(1);
                        end
`endif
                    end
                end
                ENTREGA: begin
                    credito_q <= '0;
                    estado_q  <= OCIOSO;
                    rejeita_q <= moeda_ed;
                end
                DEVOLUCAO: begin
                    // credito shows the coins still owed, including this cycle's pulse.
                    credito_q <= credito_q - CRED_W'(1);
                    rejeita_q <= moeda_ed;
                    if (credito_q <= CRED_W'(1)) begin
                        estado_q <= OCIOSO;
                    end else begin
                        devolve_q <= 1'b1;
                    end
                end
                default: begin
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign bus.carrega1 = carrega1_q;
    assign bus.carrega2 = carrega2_q;
    assign bus.credito  = credito_q;
    assign bus.devolve  = devolve_q;
    assign bus.rejeita  = rejeita_q;
    assign bus.estado   = estado_q;

endmodule

// File: tb/tb_recarga_cartao.sv
// Self-checking bench for recarga_cartao: directed scenarios plus randomized
// transactions checked against a transaction-level model (credit = min(coins,3),
// rejections = coins beyond 3, load/refund amount = credit, target = first sel).
// Honours RECARGA_TIMEOUT_EN when it is defined for the build.
module tb_recarga_cartao;

    localparam int unsigned TIMEOUT = 8;

    logic clk_2   = 1'b0;
    logic reset_n = 1'b1;

    int errors = 0;
    int checks = 0;

    recarga_cartao_if intf ();

    recarga_cartao #(.TIMEOUT(TIMEOUT)) dut (
        .clk_2   (clk_2),
        .reset_n (reset_n),
        .bus     (intf.slave)
    );

    always #5 clk_2 = ~clk_2;

    // Advance past the next rising edge and settle.
    task automatic tick;
        @(posedge clk_2);
        #1;
    endtask

    // One coin: rising edge, then falling edge, then an optional idle gap.
    task automatic drop_coin(input logic s, input int gap, output logic rej);
        intf.sel   = s;
        intf.moeda = 1'b1;
        tick();
        rej = intf.rejeita;
        intf.moeda = 1'b0;
        tick();
        for (int g = 0; g < gap; g++) tick();
    endtask

    // First coin uses s; later coins carry a random sel that must be ignored.
    task automatic load_coins(input logic s, input int n, output int rejs);
        logic r;
        rejs = 0;
        for (int i = 0; i < n; i++) begin
            drop_coin((i == 0) ? s : 1'($urandom_range(0, 1)),
                      (i < 2) ? int'($urandom_range(0, 2)) : 0, r);
            if (r) rejs++;
        end
    endtask

    task automatic test_reset;
        intf.moeda = 0; intf.sel = 0; intf.confirma = 0; intf.cancela = 0;
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (intf.estado !== 2'd0 || intf.credito !== 3'd0 || intf.carrega1 !== 2'd0 ||
            intf.carrega2 !== 2'd0 || intf.devolve !== 1'b0 || intf.rejeita !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got estado=%0d credito=%0d c1=%0d c2=%0d dev=%0d rej=%0d exp all 0",
                     intf.estado, intf.credito, intf.carrega1, intf.carrega2, intf.devolve, intf.rejeita);
        end
        @(negedge clk_2);
        reset_n = 1'b1;
        tick();
        checks++;
        if (intf.estado !== 2'd0) begin
            errors++;
            $display("FAIL reset_release_estado got=%0d exp=0", intf.estado);
        end
    endtask

    task automatic test_delivery(input logic s, input int n);
        int rejs;
        int exp_cred;
        int exp_rej;
        load_coins(s, n, rejs);
        exp_cred = (n > 3) ? 3 : n;
        exp_rej  = (n > 3) ? n - 3 : 0;
        checks++;
        if (intf.credito !== 3'(exp_cred) || intf.estado !== 2'd1) begin
            errors++;
            $display("FAIL deliv_accum got credito=%0d estado=%0d exp credito=%0d estado=1",
                     intf.credito, intf.estado, exp_cred);
        end
        checks++;
        if (rejs != exp_rej) begin
            errors++;
            $display("FAIL deliv_rejeita got=%0d exp=%0d (coins=%0d)", rejs, exp_rej, n);
        end
        intf.sel = ~s;
        intf.confirma = 1'b1;
        tick();
        checks++;
        if (intf.estado !== 2'd2 || intf.carrega1 !== 2'(s ? 0 : exp_cred) ||
            intf.carrega2 !== 2'(s ? exp_cred : 0)) begin
            errors++;
            $display("FAIL deliv_load got estado=%0d c1=%0d c2=%0d exp estado=2 c1=%0d c2=%0d (sel=%0d)",
                     intf.estado, intf.carrega1, intf.carrega2, s ? 0 : exp_cred, s ? exp_cred : 0, s);
        end
        intf.confirma = 1'b0;
        tick();
        checks++;
        if (intf.estado !== 2'd0 || intf.credito !== 3'd0 ||
            intf.carrega1 !== 2'd0 || intf.carrega2 !== 2'd0) begin
            errors++;
            $display("FAIL deliv_after got estado=%0d credito=%0d c1=%0d c2=%0d exp all 0",
                     intf.estado, intf.credito, intf.carrega1, intf.carrega2);
        end
    endtask

    task automatic test_cancel(input logic s, input int n);
        int rejs;
        int exp_cred;
        int pulses;
        int k;
        load_coins(s, n, rejs);
        exp_cred = (n > 3) ? 3 : n;
        intf.cancela = 1'b1;
        tick();
        intf.cancela = 1'b0;
        pulses = 0;
        k = 0;
        while (intf.estado !== 2'd0 && k < 10) begin
            if (intf.devolve === 1'b1) pulses++;
            checks++;
            if (intf.credito !== 3'(exp_cred - k) || intf.carrega1 !== 2'd0 || intf.carrega2 !== 2'd0) begin
                errors++;
                $display("FAIL cancel_step%0d got credito=%0d c1=%0d c2=%0d exp credito=%0d c1=0 c2=0",
                         k, intf.credito, intf.carrega1, intf.carrega2, exp_cred - k);
            end
            tick();
            k++;
        end
        checks++;
        if (pulses != exp_cred || intf.credito !== 3'd0 || intf.devolve !== 1'b0) begin
            errors++;
            $display("FAIL cancel_refund got pulses=%0d credito=%0d devolve=%0d exp pulses=%0d credito=0 devolve=0",
                     pulses, intf.credito, intf.devolve, exp_cred);
        end
        checks++;
        if (intf.estado !== 2'd0) begin
            errors++;
            $display("FAIL cancel_end_estado got=%0d exp=0", intf.estado);
        end
    endtask

    task automatic test_both_buttons;
        int rejs;
        int pulses;
        bit loaded;
        load_coins(1'b0, 2, rejs);
        intf.confirma = 1'b1;
        intf.cancela  = 1'b1;
        tick();
        intf.confirma = 1'b0;
        intf.cancela  = 1'b0;
        checks++;
        if (intf.estado !== 2'd3) begin
            errors++;
            $display("FAIL both_estado got=%0d exp=3", intf.estado);
        end
        pulses = 0;
        loaded = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (intf.devolve === 1'b1) pulses++;
            if (intf.carrega1 !== 2'd0 || intf.carrega2 !== 2'd0) loaded = 1'b1;
            tick();
        end
        checks++;
        if (pulses != 2 || loaded) begin
            errors++;
            $display("FAIL both_refund got pulses=%0d loaded=%0d exp pulses=2 loaded=0", pulses, loaded);
        end
    endtask

    task automatic test_idle_buttons;
        intf.confirma = 1'b1;
        tick();
        intf.confirma = 1'b0;
        checks++;
        if (intf.estado !== 2'd0 || intf.carrega1 !== 2'd0 || intf.carrega2 !== 2'd0) begin
            errors++;
            $display("FAIL idle_confirma got estado=%0d c1=%0d c2=%0d exp 0", intf.estado, intf.carrega1, intf.carrega2);
        end
        intf.cancela = 1'b1;
        tick();
        intf.cancela = 1'b0;
        checks++;
        if (intf.estado !== 2'd0 || intf.devolve !== 1'b0) begin
            errors++;
            $display("FAIL idle_cancela got estado=%0d devolve=%0d exp 0", intf.estado, intf.devolve);
        end
        tick();
    endtask

    task automatic test_reject_states;
        logic r;
        // Coin together with confirma in ACUMULANDO loses on priority.
        drop_coin(1'b0, 0, r);
        intf.moeda = 1'b1;
        intf.confirma = 1'b1;
        tick();
        checks++;
        if (intf.estado !== 2'd2 || intf.rejeita !== 1'b1 || intf.carrega1 !== 2'd1) begin
            errors++;
            $display("FAIL prio_coin got estado=%0d rej=%0d c1=%0d exp estado=2 rej=1 c1=1",
                     intf.estado, intf.rejeita, intf.carrega1);
        end
        intf.moeda = 1'b0;
        intf.confirma = 1'b0;
        tick();
        // Coin arriving during ENTREGA.
        drop_coin(1'b1, 0, r);
        intf.confirma = 1'b1;
        tick();
        intf.confirma = 1'b0;
        intf.moeda = 1'b1;
        tick();
        checks++;
        if (intf.rejeita !== 1'b1 || intf.estado !== 2'd0 || intf.credito !== 3'd0) begin
            errors++;
            $display("FAIL entrega_coin got rej=%0d estado=%0d credito=%0d exp rej=1 estado=0 credito=0",
                     intf.rejeita, intf.estado, intf.credito);
        end
        intf.moeda = 1'b0;
        tick();
        // Coin arriving during DEVOLUCAO.
        drop_coin(1'b0, 0, r);
        drop_coin(1'b0, 0, r);
        intf.cancela = 1'b1;
        tick();
        intf.cancela = 1'b0;
        intf.moeda = 1'b1;
        tick();
        checks++;
        if (intf.rejeita !== 1'b1 || intf.estado !== 2'd3 || intf.credito !== 3'd1) begin
            errors++;
            $display("FAIL devol_coin got rej=%0d estado=%0d credito=%0d exp rej=1 estado=3 credito=1",
                     intf.rejeita, intf.estado, intf.credito);
        end
        intf.moeda = 1'b0;
        tick();
        checks++;
        if (intf.estado !== 2'd0) begin
            errors++;
            $display("FAIL devol_coin_end got estado=%0d exp=0", intf.estado);
        end
    endtask

    task automatic test_timeout;
        logic r;
        int idle;
        int pulses;
        drop_coin(1'b1, 0, r);
        idle = 1;
`ifdef RECARGA_TIMEOUT_EN
        while (intf.estado !== 2'd3 && idle < 40) begin
            tick();
            idle++;
        end
        checks++;
        if (idle != int'(TIMEOUT) || intf.devolve !== 1'b1 || intf.credito !== 3'd1) begin
            errors++;
            $display("FAIL timeout got idle=%0d devolve=%0d credito=%0d exp idle=%0d devolve=1 credito=1",
                     idle, intf.devolve, intf.credito, TIMEOUT);
        end
        tick();
        checks++;
        if (intf.estado !== 2'd0 || intf.devolve !== 1'b0) begin
            errors++;
            $display("FAIL timeout_end got estado=%0d devolve=%0d exp 0", intf.estado, intf.devolve);
        end
`else
        pulses = 0;
        for (int k = 0; k < 3 * int'(TIMEOUT); k++) begin
            tick();
            if (intf.devolve === 1'b1) pulses++;
        end
        checks++;
        if (intf.estado !== 2'd1 || pulses != 0 || intf.credito !== 3'd1) begin
            errors++;
            $display("FAIL no_timeout got estado=%0d pulses=%0d credito=%0d exp estado=1 pulses=0 credito=1",
                     intf.estado, pulses, intf.credito);
        end
        intf.cancela = 1'b1;
        tick();
        intf.cancela = 1'b0;
        tick();
`endif
    endtask

    task automatic test_reset_mid;
        int rejs;
        int pulses;
        load_coins(1'b0, 3, rejs);
        intf.cancela = 1'b1;
        tick();
        intf.cancela = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (intf.estado !== 2'd0 || intf.credito !== 3'd0 || intf.devolve !== 1'b0 ||
            intf.rejeita !== 1'b0 || intf.carrega1 !== 2'd0 || intf.carrega2 !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid got estado=%0d credito=%0d devolve=%0d rej=%0d exp all 0",
                     intf.estado, intf.credito, intf.devolve, intf.rejeita);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (intf.devolve === 1'b1) pulses++;
        end
        @(negedge clk_2);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (intf.devolve === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || intf.estado !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_after got pulses=%0d estado=%0d exp 0", pulses, intf.estado);
        end
    endtask

    task automatic test_random;
        logic s;
        int n;
        for (int t = 0; t < 12; t++) begin
            s = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 5));
            if ($urandom_range(0, 1) == 1) test_delivery(s, n);
            else test_cancel(s, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_delivery(1'b1, 2);
        test_delivery(1'b0, 4);
        test_cancel(1'b0, 3);
        test_both_buttons();
        test_idle_buttons();
        test_reject_states();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/recarga_cartao.md
RECARGA_CARTAO -- requirements
Module: recarga_cartao

Interface
REQ-001 Parameter TIMEOUT, default 8: idle cycles in ACUMULANDO before automatic refund; legal range 1-255.
REQ-002 clk_2  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 moeda  in  1  coin sensor level; each 0->1 transition is one coin of 1 unit.
REQ-005 sel  in  1  target card: 0 = passenger 1, 1 = passenger 2.
REQ-006 confirma  in  1  confirm button level; edge-detected.
REQ-007 cancela  in  1  cancel button level; edge-detected.
REQ-008 carrega1  out  2  load value for card 1; feeds the turnstile's carrega1 input.
REQ-009 carrega2  out  2  load value for card 2; feeds the turnstile's carrega2 input.
REQ-010 credito  out  3  coins held in the current transaction (0-3).
REQ-011 devolve  out  1  refund pulse; one cycle high per coin returned.
REQ-012 rejeita  out  1  one-cycle pulse when a coin edge is not accepted.
REQ-013 estado  out  2  current FSM state for debug: OCIOSO=0, ACUMULANDO=1, ENTREGA=2, DEVOLUCAO=3.

Function
REQ-014 Edge detection: moeda, confirma and cancela are each registered once; an edge is current=1 with previous sample=0.
REQ-015 Input priority within a cycle: cancela edge, then confirma edge, then moeda edge.
REQ-016 A coin edge ignored because of priority, state or the credit limit produces rejeita=1 in the next cycle.
REQ-017 OCIOSO: credito=0.
REQ-018 OCIOSO, moeda edge: set credito=1, latch sel into internal alvo, go to ACUMULANDO.
REQ-019 OCIOSO: confirma and cancela edges have no effect.
REQ-020 ACUMULANDO: a moeda edge with credito<3 increments credito.
REQ-021 ACUMULANDO: a moeda edge with credito==3 leaves credito unchanged and pulses rejeita.
REQ-022 ACUMULANDO: a confirma edge moves the FSM to ENTREGA.
REQ-023 ACUMULANDO: a cancela edge moves the FSM to DEVOLUCAO.
REQ-024 alvo does not change after the first coin; later changes on sel are ignored until the FSM returns to OCIOSO.
REQ-025 ENTREGA lasts exactly one cycle.
REQ-026 In ENTREGA, carrega of the card selected by alvo equals credito; the other carrega output is 0.
REQ-027 On leaving ENTREGA: credito goes to 0 and the FSM goes to OCIOSO.
REQ-028 Latency: a confirma edge sampled at edge N puts a nonzero carrega on the output for cycle N+1 only.
REQ-029 Outside ENTREGA, carrega1 and carrega2 are 0.
REQ-030 DEVOLUCAO, each cycle: devolve=1 and credito decrements by 1.
REQ-031 DEVOLUCAO goes to OCIOSO on the cycle credito reaches 0, giving exactly credito devolve pulses in total.
REQ-032 Coin edges in ENTREGA or DEVOLUCAO pulse rejeita.
REQ-033 Button edges in ENTREGA or DEVOLUCAO are ignored.
REQ-034 All outputs are registered or decoded from registered state; no combinational path from any input to any output.

Reset
REQ-035 When reset_n=0, immediately and independent of the clock: state=OCIOSO, credito=0, carrega1=carrega2=0, devolve=0, rejeita=0, timer=0, edge registers=0.
REQ-036 Reset mid-transaction discards held credit; no devolve pulse is produced for it.

Configuration
REQ-037 Macro RECARGA_TIMEOUT_EN selects the inactivity timeout.
REQ-038 With RECARGA_TIMEOUT_EN defined: timer counts cycles in ACUMULANDO and clears on each accepted coin.
REQ-039 With RECARGA_TIMEOUT_EN defined: when the timer reaches TIMEOUT, the FSM goes to DEVOLUCAO as if cancela were pressed.
REQ-040 Without RECARGA_TIMEOUT_EN: no timer exists, and ACUMULANDO is left only on a confirma or cancela edge.

Verification
REQ-041 sel=1, 2 coins, then confirma: carrega2=2 for one cycle, carrega1=0, credito returns to 0, estado=OCIOSO.
REQ-042 sel=0, 4 coins: credito=3, rejeita pulses once on the 4th coin; confirma then gives carrega1=3.
REQ-043 3 coins, then cancela: devolve high 3 consecutive cycles, credito goes 3->2->1->0, then OCIOSO.
REQ-044 Confirma and cancela edges in the same cycle with credito=2: DEVOLUCAO, 2 devolve pulses, carrega outputs stay 0.
REQ-045 Build with RECARGA_TIMEOUT_EN, TIMEOUT=8, 1 coin then no input: DEVOLUCAO after 8 cycles, 1 devolve pulse.
REQ-046 reset_n low during DEVOLUCAO with credito=2, asserted between clock edges: outputs clear at once, no further devolve pulses.
